kmeans_frame_tx: RTL and testbench

Host-side frame transmitter and result collector for the kMeans clustering engine. On a start pulse it reads one frame of CLUSTER_SIZE initial centroids followed by DATA_SIZE points from a synchronous source buffer. It drives them to the engine's in_valid/in_data port as a single gap-free burst, then captures the CLUSTER_SIZE result words returned on out_valid/out_data. It sits between the host-loaded frame RAM and the engine.

---
 rtl/kmeans_frame_tx.sv | 131 +++++++++++++
 tb/tb_kmeans_frame_tx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/kmeans_frame_tx.sv
// rtl/kmeans_frame_tx.sv - frame burst transmitter and result collector for the kMeans engine
// Optional result-wait timeout: KMEANS_TX_TIMEOUT_EN
module kmeans_frame_tx #(
  parameter int CLUSTER_SIZE   = 4,
  parameter int DATA_SIZE      = 4096,
  parameter int ADDR_W         = 13,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              src_rd,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [15:0]       src_data,
  output logic              tx_valid,
  output logic [15:0]       tx_data,
  input  logic              rx_valid,
  input  logic [15:0]       rx_data,
  output logic [15:0]       res0,
  output logic [15:0]       res1,
  output logic [15:0]       res2,
  output logic [15:0]       res3
);

  localparam int N = CLUSTER_SIZE + DATA_SIZE;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, WAIT_RES} state_t;

  state_t            state, next_state;
  logic [1:0]        rx_cnt;
  logic              rd_d;
  logic              timeout;
  logic              last_rx;
  logic              accept;
  logic              src_rd_nx, busy_nx, done_nx, error_nx;
  logic [ADDR_W-1:0] src_addr_nx;

  assign last_rx = (state == WAIT_RES) && rx_valid && (rx_cnt == 2'd3);
  // A start landing on the done cycle is dropped: done is only high while back in IDLE.
  assign accept  = (state == IDLE) && start && !done;

`ifdef KMEANS_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || state != WAIT_RES) tmo_cnt <= '0;
    else                             tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign timeout = (state == WAIT_RES) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES > 0);
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (accept) next_state = READ;
      READ:     if (src_addr == ADDR_W'(N - 1)) next_state = DRAIN;
      DRAIN:    if (tx_valid && !rd_d) next_state = WAIT_RES;
      WAIT_RES: if (last_rx || timeout) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    src_rd_nx   = (next_state == READ);
    src_addr_nx = '0;
    if (state == READ && next_state == READ) src_addr_nx = src_addr + ADDR_W'(1);
    busy_nx     = (next_state != IDLE);
    done_nx     = (state == WAIT_RES) && (next_state == IDLE);
    error_nx    = error;
    if (accept)       error_nx = 1'b0;
    else if (done_nx) error_nx = timeout && !last_rx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_rd   <= 1'b0;
      src_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      rd_d     <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      src_rd   <= src_rd_nx;
      src_addr <= src_addr_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      error    <= error_nx;
      // src_data is valid the cycle after src_rd; rd_d marks that cycle.
      rd_d     <= src_rd;
      tx_valid <= rd_d;
      tx_data  <= rd_d ? src_data : 16'h0000;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_cnt <= 2'd0;
      res0   <= '0;
      res1   <= '0;
      res2   <= '0;
      res3   <= '0;
    end else if (accept) begin
      rx_cnt <= 2'd0;
    end else if (state == WAIT_RES && rx_valid) begin
      rx_cnt <= rx_cnt + 1'b1;
      case (rx_cnt)
        2'd0:    res0 <= rx_data;
        2'd1:    res1 <= rx_data;
        2'd2:    res2 <= rx_data;
        default: res3 <= rx_data;
      endcase
    end
  end

endmodule

// File: tb/tb_kmeans_frame_tx.sv
// tb/tb_kmeans_frame_tx.sv - self-checking bench for kmeans_frame_tx
// Frame-level model predicts every output per cycle; directed frames add literal checks.
module tb_kmeans_frame_tx;

  localparam int N   = 4100;
  localparam int TMO = 100;
  localparam int BIG = 1 << 30;

  logic        clk = 1'b0;
  logic        rst_n, start, rx_valid;
  logic [15:0] rx_data, src_data;
  logic        busy, done, error, src_rd, tx_valid;
  logic [12:0] src_addr;
  logic [15:0] tx_data, res0, res1, res2, res3;

  kmeans_frame_tx #(.CLUSTER_SIZE(4), .DATA_SIZE(4096), .ADDR_W(13), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .error(error),
    .src_rd(src_rd), .src_addr(src_addr), .src_data(src_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .rx_valid(rx_valid), .rx_data(rx_data),
    .res0(res0), .res1(res1), .res2(res2), .res3(res3)
  );

  always #5 clk = ~clk;

  // Source RAM: word[i] = i ^ pat, one-cycle read latency.
  logic [15:0] pat = 16'h0000;
  always @(posedge clk) if (src_rd) src_data <= {3'b000, src_addr} ^ pat;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Frame model: t0 is the cycle start was driven in; c counts cycles from there.
  bit          chk_en = 0, active = 0, exp_err = 0;
  int          t0 = 0, k = 0, done_at = BIG, done_cnt = 0;
  logic [15:0] exp_res [4] = '{16'h0, 16'h0, 16'h0, 16'h0};

  always @(negedge clk) begin
    int c;
    bit e_rd, e_tv, e_busy, e_done;
    c = active ? cyc - t0 : -1;
    if (chk_en) begin
      e_rd   = active && c >= 1 && c <= N;
      e_tv   = active && c >= 3 && c <= N + 2;
      e_busy = active && c >= 1 && c < done_at;
      e_done = active && c == done_at;
      chk("src_rd", src_rd, e_rd);
      chk("src_addr", src_addr, e_rd ? c - 1 : 0);
      chk("tx_valid", tx_valid, e_tv);
      chk("tx_data", tx_data, e_tv ? ((c - 3) & 16'hffff) ^ pat : 0);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("error", error, exp_err);
      chk("res0", res0, exp_res[0]);
      chk("res1", res1, exp_res[1]);
      chk("res2", res2, exp_res[2]);
      chk("res3", res3, exp_res[3]);
      if (done) done_cnt++;
    end
    if (!rst_n) begin
      chk_en  = 1;
      active  = 0;
      exp_err = 0;
      done_at = BIG;
      exp_res = '{16'h0, 16'h0, 16'h0, 16'h0};
    end else if (active) begin
      if (c == 0) exp_err = 0;
      // Results are only taken once the burst has drained (cycle N+3 onward).
      if (rx_valid && c >= N + 3 && k < 4) begin
        exp_res[k] = rx_data;
        k++;
        if (k == 4) done_at = c + 1;
      end
`ifdef KMEANS_TX_TIMEOUT_EN
      if (done_at == BIG && c == N + 3 + TMO - 1) begin
        done_at = c + 1;
        exp_err = 1;
      end
`endif
      if (c == done_at) active = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    start   = 1'b1;
    t0      = cyc;
    k       = 0;
    done_at = BIG;
    active  = 1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_burst_end(input string name);
    int n = 0;
    while (!tx_valid && n < 20) begin tick(); n++; end
    n = 0;
    while (tx_valid && n < N + 10) begin tick(); n++; end
    chk(name, tx_valid, 0);
  endtask

  task automatic send_rx(input logic [15:0] w);
    rx_valid = 1'b1;
    rx_data  = w;
    tick();
    rx_valid = 1'b0;
    rx_data  = 16'h0;
  endtask

  initial begin
    int n, len;
    logic [15:0] words [4];
    words = '{16'h1020, 16'h3040, 16'h5060, 16'h7080};
    rst_n = 1'b0; start = 1'b1; rx_valid = 1'b0; rx_data = 16'h0;
    repeat (3) tick();
    chk("reset_busy", busy, 0);
    chk("reset_res0", res0, 0);
    rst_n = 1'b1; start = 1'b0;
    repeat (3) tick();

    // Nominal frame with stray rx and start pulses during the burst.
    start_frame();
    n = 1;
    while (!tx_valid && n < 20) begin tick(); n++; end
    chk("tx_latency", n, 3);
    len = 0;
    while (tx_valid && len < N + 10) begin
      len++;
      rx_valid = (len == 100);
      rx_data  = (len == 100) ? 16'hDEAD : 16'h0;
      start    = (len == 200 || len == 201);
      tick();
    end
    rx_valid = 1'b0; start = 1'b0;
    chk("tx_burst_len", len, N);
    for (int i = 0; i < 4; i++) send_rx(words[i]);
    chk("done_pulse", done, 1);
    start = 1'b1;
    send_rx(16'hBEEF);
    start = 1'b0;
    tick();
    chk("res0_lit", res0, 16'h1020);
    chk("res1_lit", res1, 16'h3040);
    chk("res2_lit", res2, 16'h5060);
    chk("res3_lit", res3, 16'h7080);
    chk("done_count", done_cnt, 1);
    chk("idle_after_done", busy, 0);

    // Second frame with a different pattern, reset at tx word 2000.
    pat = 16'h5A5A;
    start_frame();
    n = 0;
    while (!(tx_valid && tx_data == (16'd2000 ^ pat)) && n < N) begin tick(); n++; end
    chk("reached_word_2000", cyc - t0, 2003);
    rst_n = 1'b0;
    tick();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    start_frame();
    wait_burst_end("burst2_end");
    for (int i = 0; i < 4; i++) send_rx(16'h0101 * (i + 1));
    tick();
    chk("res3_frame2", res3, 16'h0404);

`ifdef KMEANS_TX_TIMEOUT_EN
    pat = 16'h0000;
    start_frame();
    wait_burst_end("burst3_end");
    send_rx(16'hAAAA);
    send_rx(16'hBBBB);
    n = 0;
    while (!done && n < TMO + 20) begin tick(); n++; end
    chk("timeout_time", cyc - t0, N + 3 + TMO);
    chk("timeout_error", error, 1);
    chk("timeout_res0", res0, 16'hAAAA);
    chk("timeout_res2", res2, 16'h0303);
    tick();
    start_frame();
    chk("error_cleared", error, 0);
    repeat (5) tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
